// File: rtl/key_pkg.sv
// Shared types and default constants for the key debounce block.
package key_pkg;

    localparam int W_KEY_DEF        = 4;
    localparam int W_CNT_DEF        = 16;
    localparam int DEBOUNCE_CNT_DEF = 1000;
    localparam int HOLD_CNT_DEF     = 4000;

    typedef logic [W_CNT_DEF-1:0] cnt_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: two-flop synchronizer, debounce counter, press/release pulses and,
// with KEY_DEBOUNCE_HOLD_EN defined, a long-press hold counter.
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int w_cnt        = W_CNT_DEF,
    parameter int debounce_cnt = DEBOUNCE_CNT_DEF,
    parameter int hold_cnt     = HOLD_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_state,
    output logic o_pressed,
    output logic o_released,
    output logic o_held
);

    if (debounce_cnt < 1 || hold_cnt < 1 ||
        debounce_cnt > (2**w_cnt - 1) || hold_cnt > (2**w_cnt - 1)) begin : g_bad_param
        $error("key_debounce_cell: debounce_cnt/hold_cnt out of range for w_cnt");
    end

    localparam logic [w_cnt-1:0] DB_LAST = w_cnt'(debounce_cnt - 1);

    logic             r_s1;
    logic             r_s2;
    logic [w_cnt-1:0] r_cnt;
    logic             r_state;
    logic             r_pressed;
    logic             r_released;
    logic             w_accept;
    logic             w_state_nxt;

    assign w_accept    = (r_s2 != r_state) && (r_cnt == DB_LAST);
    assign w_state_nxt = w_accept ? r_s2 : r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_cnt      <= '0;
            r_state    <= 1'b0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
        end else begin
            r_s1       <= i_key;
            r_s2       <= r_s1;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            // Any sample matching the stable level restarts the count.
            if (r_s2 == r_state) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_state    <= r_s2;
                r_cnt      <= '0;
                r_pressed  <= r_s2;
                r_released <= ~r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_state    = r_state;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;

`ifdef KEY_DEBOUNCE_HOLD_EN
    localparam logic [w_cnt-1:0] HOLD_LAST = w_cnt'(hold_cnt - 1);

    logic [w_cnt-1:0] r_hcnt;
    logic             r_held;

    // Keyed off the next state so key_held falls on the release edge itself,
    // while counting only starts the cycle after the press is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt <= '0;
            r_held <= 1'b0;
        end else if (!w_state_nxt) begin
            r_hcnt <= '0;
            r_held <= 1'b0;
        end else if (r_state) begin
            if (r_hcnt == HOLD_LAST) begin
                r_held <= 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    assign o_held = r_held;
`else
    assign o_held = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounces w_key independent raw key inputs; long-press detection is built
// only when KEY_DEBOUNCE_HOLD_EN is defined (key_held reads 0 otherwise).
module key_debounce
    import key_pkg::*;
#(
    parameter int w_key        = W_KEY_DEF,
    parameter int w_cnt        = W_CNT_DEF,
    parameter int debounce_cnt = DEBOUNCE_CNT_DEF,
    parameter int hold_cnt     = HOLD_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [w_key-1:0] key,
    output logic [w_key-1:0] key_state,
    output logic [w_key-1:0] key_pressed,
    output logic [w_key-1:0] key_released,
    output logic [w_key-1:0] key_held
);

    for (genvar i = 0; i < w_key; i++) begin : g_cell
        key_debounce_cell #(
            .w_cnt        (w_cnt),
            .debounce_cnt (debounce_cnt),
            .hold_cnt     (hold_cnt)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .i_key      (key[i]),
            .o_state    (key_state[i]),
            .o_pressed  (key_pressed[i]),
            .o_released (key_released[i]),
            .o_held     (key_held[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with debounce_cnt=4, hold_cnt=8, w_key=4.
module tb_key_debounce;

    localparam int W_KEY = 4;
    localparam int W_CNT = 16;
    localparam int DB    = 4;
    localparam int HOLD  = 8;
`ifdef KEY_DEBOUNCE_HOLD_EN
    localparam logic HOLD_EN = 1'b1;
`else
    localparam logic HOLD_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [W_KEY-1:0] key = '0;
    logic [W_KEY-1:0] key_state;
    logic [W_KEY-1:0] key_pressed;
    logic [W_KEY-1:0] key_released;
    logic [W_KEY-1:0] key_held;

    int n_checks = 0;
    int n_fail   = 0;

    key_debounce #(
        .w_key        (W_KEY),
        .w_cnt        (W_CNT),
        .debounce_cnt (DB),
        .hold_cnt     (HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .key_state    (key_state),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .key_held     (key_held)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] st, input logic [3:0] pr,
                              input logic [3:0] rl, input logic [3:0] hd);
        check({tag, ".state"},    32'(key_state),    32'(st));
        check({tag, ".pressed"},  32'(key_pressed),  32'(pr));
        check({tag, ".released"}, 32'(key_released), 32'(rl));
        check({tag, ".held"},     32'(key_held),     32'(hd));
    endtask

    initial begin
        // 1: reset with all keys high
        key = 4'hF;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs("t1_rst", 4'h0, 4'h0, 4'h0, 4'h0);
        end
        rst = 1'b0;
        key = 4'h0;
        step();
        check_outs("t1_post", 4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) step();

        // 2 + 6: clean press on key 0, hold, release
        key = 4'h1;
        for (int e = 1; e <= 5; e++) begin
            step();
            check_outs("t2_wait", 4'h0, 4'h0, 4'h0, 4'h0);
        end
        step();
        check_outs("t2_acc", 4'h1, 4'h1, 4'h0, 4'h0);
        for (int k = 1; k <= HOLD; k++) begin
            step();
            check_outs("t6_hold", 4'h1, 4'h0, 4'h0, {3'b0, HOLD_EN && (k == HOLD)});
        end
        key = 4'h0;
        for (int e = 1; e <= 5; e++) begin
            step();
            check_outs("t6_relwait", 4'h1, 4'h0, 4'h0, {3'b0, HOLD_EN});
        end
        step();
        check_outs("t6_rel", 4'h0, 4'h0, 4'h1, 4'h0);
        step();
        check_outs("t6_relafter", 4'h0, 4'h0, 4'h0, 4'h0);

        // 3: 3-cycle glitch on key 1 is filtered
        key = 4'h2;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs("t3_hi", 4'h0, 4'h0, 4'h0, 4'h0);
        end
        key = 4'h0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_outs("t3_lo", 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // 4: key 2 bounces 1,0,1,0 then steady 1
        for (int b = 0; b < 4; b++) begin
            key = (b % 2 == 0) ? 4'h4 : 4'h0;
            step();
            check_outs("t4_bounce", 4'h0, 4'h0, 4'h0, 4'h0);
        end
        key = 4'h4;
        for (int e = 1; e <= 5; e++) begin
            step();
            check_outs("t4_wait", 4'h0, 4'h0, 4'h0, 4'h0);
        end
        step();
        check_outs("t4_acc", 4'h4, 4'h4, 4'h0, 4'h0);
        step();
        check_outs("t4_after", 4'h4, 4'h0, 4'h0, 4'h0);
        key = 4'h0;
        for (int e = 1; e <= 5; e++) step();
        step();
        check_outs("t4_rel", 4'h0, 4'h0, 4'h4, 4'h0);
        for (int i = 0; i < 2; i++) step();

        // 5: keys 0 and 3 together
        key = 4'h9;
        for (int e = 1; e <= 5; e++) step();
        check_outs("t5_wait", 4'h0, 4'h0, 4'h0, 4'h0);
        step();
        check_outs("t5_press", 4'h9, 4'h9, 4'h0, 4'h0);
        step();
        check_outs("t5_pafter", 4'h9, 4'h0, 4'h0, 4'h0);
        key = 4'h0;
        for (int e = 1; e <= 5; e++) step();
        check_outs("t5_relwait", 4'h9, 4'h0, 4'h0, 4'h0);
        step();
        check_outs("t5_rel", 4'h0, 4'h0, 4'h9, 4'h0);
        step();
        check_outs("t5_rafter", 4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 2; i++) step();

        // 7: reset while key 3 is mid-count and key 0 is accepted
        key = 4'h1;
        for (int e = 1; e <= 6; e++) step();
        check_outs("t7_k0", 4'h1, 4'h1, 4'h0, 4'h0);
        key = 4'h9;
        for (int e = 1; e <= 4; e++) begin
            step();
            check_outs("t7_mid", 4'h1, 4'h0, 4'h0, 4'h0);
        end
        rst = 1'b1;
        step();
        check_outs("t7_rst", 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            check_outs("t7_recount", 4'h0, 4'h0, 4'h0, 4'h0);
        end
        step();
        check_outs("t7_acc", 4'h9, 4'h9, 4'h0, 4'h0);
        step();
        check_outs("t7_after", 4'h9, 4'h0, 4'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
